// File: rtl/atm_pkg.sv
// Shared definitions for the ATM controller: state encoding, transaction
// type codes and default sizing.
package atm_pkg;

    localparam int DEF_PIN_DIGITS = 4;
    localparam int DEF_MAX_TRIES  = 3;

    localparam logic TX_DEPOSITO = 1'b0;
    localparam logic TX_RETIRO   = 1'b1;

    localparam logic [2:0] ENC_IDLE       = 3'd0;
    localparam logic [2:0] ENC_PIN_ENTRY  = 3'd1;
    localparam logic [2:0] ENC_PIN_CHECK  = 3'd2;
    localparam logic [2:0] ENC_WAIT_MONTO = 3'd3;
    localparam logic [2:0] ENC_EXEC       = 3'd4;
    localparam logic [2:0] ENC_BLOCKED    = 3'd5;

    typedef enum logic [2:0] {
        IDLE       = ENC_IDLE,
        PIN_ENTRY  = ENC_PIN_ENTRY,
        PIN_CHECK  = ENC_PIN_CHECK,
        WAIT_MONTO = ENC_WAIT_MONTO,
        EXEC       = ENC_EXEC,
        BLOCKED    = ENC_BLOCKED
    } state_t;

endpackage

// File: rtl/atm_stb_edge.sv
// Rising-edge detector for a level strobe; a high level of any length
// produces a single one-cycle rise.
module stb_edge (
    input  logic CLK,
    input  logic RESET,
    input  logic in,
    output logic rise
);

    logic prev_p1;

    always_ff @(posedge CLK) begin
        if (!RESET) prev_p1 <= 1'b0;
        else        prev_p1 <= in;
    end

    assign rise = in & ~prev_p1;

endmodule

// File: rtl/atm_controller.sv
// ATM transaction controller: card acceptance, PIN verification with retry
// limit, and a single deposit or withdrawal against a saturating balance.
module atm_controller
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS = DEF_PIN_DIGITS,
    parameter int MAX_TRIES  = DEF_MAX_TRIES,
    parameter int BAL_W      = 64,
    parameter int MONTO_W    = 32
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    TARJETA_RECIBIDA,
    input  logic [3:0]              DIGITO,
    input  logic                    DIGITO_STB,
    input  logic [4*PIN_DIGITS-1:0] PIN_CORRECTO,
    input  logic                    TIPO_TRANS,
    input  logic [MONTO_W-1:0]      MONTO,
    input  logic                    MONTO_STB,
    input  logic [BAL_W-1:0]        BALANCE_INICIAL,
    output logic [BAL_W-1:0]        BALANCE,
    output logic                    BALANCE_ACTUALIZADO,
    output logic                    ENTREGAR_DINERO,
    output logic                    FONDOS_INSUFICIENTES,
    output logic                    PIN_INCORRECTO,
    output logic                    ADVERTENCIA,
    output logic                    BLOQUEO
);

    localparam int PIN_W = 4 * PIN_DIGITS;
    localparam int CNT_W = $clog2(PIN_DIGITS + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    state_t             state, state_next;
    logic               digit_rise, monto_rise;
    logic [PIN_W-1:0]   pin;
    logic [CNT_W-1:0]   cnt;
    logic [TRY_W-1:0]   tries, tries_inc;
    logic [MONTO_W-1:0] amount_p1;
    logic               tipo_p1;
    logic [BAL_W-1:0]   amount_ext;
    logic               pin_ok, last_digit;

    // Unsigned add with carry-out saturating to all-ones.
    function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] a,
                                                 input logic [MONTO_W-1:0] b);
        logic [BAL_W:0] sum;
        sum = {1'b0, a} + {{(BAL_W + 1 - MONTO_W){1'b0}}, b};
        return sum[BAL_W] ? {BAL_W{1'b1}} : sum[BAL_W-1:0];
    endfunction

    stb_edge u_digito_edge (.CLK(CLK), .RESET(RESET), .in(DIGITO_STB), .rise(digit_rise));
    stb_edge u_monto_edge  (.CLK(CLK), .RESET(RESET), .in(MONTO_STB),  .rise(monto_rise));

    assign amount_ext = {{(BAL_W - MONTO_W){1'b0}}, amount_p1};
    assign BLOQUEO    = (state == BLOCKED);

    always_ff @(posedge CLK) begin
        if (!RESET) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pin_ok     = (pin == PIN_CORRECTO);
        tries_inc  = tries + 1'b1;
        last_digit = (cnt == CNT_W'(PIN_DIGITS - 1));
        case (state)
            IDLE:       if (TARJETA_RECIBIDA) state_next = PIN_ENTRY;
            PIN_ENTRY:  if (digit_rise && last_digit) state_next = PIN_CHECK;
            PIN_CHECK: begin
                if (pin_ok)                             state_next = WAIT_MONTO;
                else if (tries_inc == TRY_W'(MAX_TRIES)) state_next = BLOCKED;
                else                                    state_next = PIN_ENTRY;
            end
            WAIT_MONTO: if (monto_rise) state_next = EXEC;
            EXEC:       state_next = IDLE;
            BLOCKED:    state_next = BLOCKED;
            default:    state_next = IDLE;
        endcase
    end

    // Datapath and result flags; flags are one-cycle pulses except ADVERTENCIA.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            BALANCE              <= BALANCE_INICIAL;
            pin                  <= '0;
            cnt                  <= '0;
            tries                <= '0;
            amount_p1            <= '0;
            tipo_p1              <= TX_DEPOSITO;
            BALANCE_ACTUALIZADO  <= 1'b0;
            ENTREGAR_DINERO      <= 1'b0;
            FONDOS_INSUFICIENTES <= 1'b0;
            PIN_INCORRECTO       <= 1'b0;
            ADVERTENCIA          <= 1'b0;
        end else begin
            BALANCE_ACTUALIZADO  <= 1'b0;
            ENTREGAR_DINERO      <= 1'b0;
            FONDOS_INSUFICIENTES <= 1'b0;
            PIN_INCORRECTO       <= 1'b0;
            case (state)
                IDLE: begin
                    if (TARJETA_RECIBIDA) begin
                        cnt   <= '0;
                        tries <= '0;
                    end
                end
                PIN_ENTRY: begin
                    if (digit_rise) begin
                        pin <= {pin[PIN_W-5:0], DIGITO};
                        cnt <= cnt + 1'b1;
                    end
                end
                PIN_CHECK: begin
                    cnt <= '0;
                    if (pin_ok) begin
                        tries       <= '0;
                        ADVERTENCIA <= 1'b0;
                    end else begin
                        PIN_INCORRECTO <= 1'b1;
                        tries          <= tries_inc;
                        if (tries_inc == TRY_W'(MAX_TRIES - 1)) ADVERTENCIA <= 1'b1;
                    end
                end
                WAIT_MONTO: begin
                    if (monto_rise) begin
                        amount_p1 <= MONTO;
                        tipo_p1   <= TIPO_TRANS;
                    end
                end
                EXEC: begin
                    if (tipo_p1 == TX_DEPOSITO) begin
                        BALANCE             <= sat_add(BALANCE, amount_p1);
                        BALANCE_ACTUALIZADO <= 1'b1;
                    end else if (amount_ext <= BALANCE) begin
                        BALANCE         <= BALANCE - amount_ext;
                        ENTREGAR_DINERO <= 1'b1;
                    end else begin
                        FONDOS_INSUFICIENTES <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_controller.sv
// Scoreboard bench for atm_controller: directed sessions push expected
// result pulses; a monitor pops and compares whenever a pulse appears.
module tb_atm_controller;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        TARJETA_RECIBIDA = 1'b0;
    logic [3:0]  DIGITO = '0;
    logic        DIGITO_STB = 1'b0;
    logic [15:0] PIN_CORRECTO = 16'h3566;
    logic        TIPO_TRANS = 1'b0;
    logic [31:0] MONTO = '0;
    logic        MONTO_STB = 1'b0;
    logic [63:0] BALANCE_INICIAL = '0;
    logic [63:0] BALANCE;
    logic        BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES;
    logic        PIN_INCORRECTO, ADVERTENCIA, BLOQUEO;

    atm_controller dut (
        .CLK(CLK), .RESET(RESET), .TARJETA_RECIBIDA(TARJETA_RECIBIDA),
        .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB), .PIN_CORRECTO(PIN_CORRECTO),
        .TIPO_TRANS(TIPO_TRANS), .MONTO(MONTO), .MONTO_STB(MONTO_STB),
        .BALANCE_INICIAL(BALANCE_INICIAL), .BALANCE(BALANCE),
        .BALANCE_ACTUALIZADO(BALANCE_ACTUALIZADO), .ENTREGAR_DINERO(ENTREGAR_DINERO),
        .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES), .PIN_INCORRECTO(PIN_INCORRECTO),
        .ADVERTENCIA(ADVERTENCIA), .BLOQUEO(BLOQUEO)
    );

    always #5 CLK = ~CLK;

    // flags = {BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES, PIN_INCORRECTO}
    typedef struct {
        string       name;
        logic [3:0]  flags;
        logic [63:0] bal;
        logic        adv;
        logic        blk;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [3:0] F_ACT = 4'b1000, F_ENT = 4'b0100, F_FON = 4'b0010, F_PIN = 4'b0001;

    always @(negedge CLK) begin
        logic [3:0] got;
        exp_t       e;
        got = {BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES, PIN_INCORRECTO};
        if (RESET && got != 4'b0000) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: got flags=%b bal=%0h adv=%b blk=%b, required no pulse",
                         got, BALANCE, ADVERTENCIA, BLOQUEO);
            end else begin
                e = exp_q.pop_front();
                if (got !== e.flags || BALANCE !== e.bal || ADVERTENCIA !== e.adv || BLOQUEO !== e.blk) begin
                    miscompares++;
                    $display("FAIL %s: got flags=%b bal=%0h adv=%b blk=%b, required flags=%b bal=%0h adv=%b blk=%b",
                             e.name, got, BALANCE, ADVERTENCIA, BLOQUEO, e.flags, e.bal, e.adv, e.blk);
                end
            end
        end
    end

    task automatic expect_out(input string name, input logic [3:0] flags,
                              input logic [63:0] bal, input logic adv, input logic blk);
        exp_t e;
        e.name = name; e.flags = flags; e.bal = bal; e.adv = adv; e.blk = blk;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) @(negedge CLK);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: timeout, got %0d pending results, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic do_reset(input logic [63:0] init);
        @(negedge CLK);
        RESET = 1'b0;
        BALANCE_INICIAL = init;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic insert_card();
        @(negedge CLK);
        TARJETA_RECIBIDA = 1'b1;
        @(negedge CLK);
        TARJETA_RECIBIDA = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] d);
        @(negedge CLK);
        DIGITO = d;
        DIGITO_STB = 1'b1;
        @(negedge CLK);
        DIGITO_STB = 1'b0;
    endtask

    task automatic enter_pin(input logic [15:0] p);
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] d;
            d = p[4*i +: 4];
            send_digit(d);
        end
    endtask

    task automatic send_amount(input logic tipo, input logic [31:0] m);
        @(negedge CLK);
        TIPO_TRANS = tipo;
        MONTO = m;
        MONTO_STB = 1'b1;
        @(negedge CLK);
        MONTO_STB = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset(64'd0);
        @(negedge CLK);
        check("reset_balance", BALANCE, 64'd0);
        check("reset_flags", {60'd0, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES, PIN_INCORRECTO}, 64'd0);
        check("reset_adv_blk", {62'd0, ADVERTENCIA, BLOQUEO}, 64'd0);

        // 1: deposit 10000
        insert_card();
        enter_pin(16'h3566);
        expect_out("deposit_10000", F_ACT, 64'd10000, 1'b0, 1'b0);
        send_amount(1'b0, 32'd10000);
        drain("deposit_10000");

        // 2: withdraw 7000
        insert_card();
        enter_pin(16'h3566);
        expect_out("withdraw_7000", F_ENT, 64'd3000, 1'b0, 1'b0);
        send_amount(1'b1, 32'd7000);
        drain("withdraw_7000");

        // 3: three wrong PINs then block
        insert_card();
        expect_out("wrong_pin_1", F_PIN, 64'd3000, 1'b0, 1'b0);
        enter_pin(16'h3561);
        drain("wrong_pin_1");
        expect_out("wrong_pin_2", F_PIN, 64'd3000, 1'b1, 1'b0);
        enter_pin(16'h1111);
        drain("wrong_pin_2");
        expect_out("wrong_pin_3", F_PIN, 64'd3000, 1'b1, 1'b1);
        enter_pin(16'h1534);
        drain("wrong_pin_3");
        insert_card();
        enter_pin(16'h3566);
        send_amount(1'b0, 32'd55);
        repeat (6) @(negedge CLK);
        check("blocked_holds", {63'd0, BLOQUEO}, 64'd1);
        check("blocked_balance", BALANCE, 64'd3000);
        do_reset(64'd0);
        @(negedge CLK);
        check("unblock_flags", {62'd0, ADVERTENCIA, BLOQUEO}, 64'd0);
        check("unblock_balance", BALANCE, 64'd0);

        // 4: insufficient funds
        insert_card();
        enter_pin(16'h3566);
        expect_out("insufficient", F_FON, 64'd0, 1'b0, 1'b0);
        send_amount(1'b1, 32'd900000);
        drain("insufficient");

        // 5: saturating deposit
        do_reset(64'hFFFF_FFFF_FFFF_FF00);
        @(negedge CLK);
        check("reset_load_balance", BALANCE, 64'hFFFF_FFFF_FFFF_FF00);
        insert_card();
        enter_pin(16'h3566);
        expect_out("deposit_saturate", F_ACT, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        send_amount(1'b0, 32'h200);
        drain("deposit_saturate");

        // 6: reset mid-PIN, then exact withdrawal and zero deposit
        do_reset(64'd500);
        insert_card();
        send_digit(4'd3);
        send_digit(4'd5);
        do_reset(64'd500);
        @(negedge CLK);
        check("midpin_reset_balance", BALANCE, 64'd500);
        insert_card();
        enter_pin(16'h3566);
        expect_out("withdraw_exact", F_ENT, 64'd0, 1'b0, 1'b0);
        send_amount(1'b1, 32'd500);
        drain("withdraw_exact");
        insert_card();
        enter_pin(16'h3566);
        expect_out("deposit_zero", F_ACT, 64'd0, 1'b0, 1'b0);
        send_amount(1'b0, 32'd0);
        drain("deposit_zero");

        // Wrong PIN then correct one clears the warning state
        insert_card();
        expect_out("retry_wrong", F_PIN, 64'd0, 1'b0, 1'b0);
        enter_pin(16'h9999);
        drain("retry_wrong");
        enter_pin(16'h3566);
        expect_out("retry_deposit", F_ACT, 64'd42, 1'b0, 1'b0);
        send_amount(1'b0, 32'd42);
        drain("retry_deposit");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
